// File: rtl/mem_controller.sv
// Multicycle Moore controller for MOV/ALU/LDR/STR/HALT with a req/ready memory handshake.
// Outputs decode from state only; RD/WR hold until mem_ready or the wait counter times out.
module mem_controller #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] opcode,
   input  logic [1:0] ALU_op,
   input  logic       mem_ready,
   output logic       waiting,
   output logic [1:0] reg_sel,
   output logic [1:0] wb_sel,
   output logic       w_en,
   output logic       en_A,
   output logic       en_B,
   output logic       en_C,
   output logic       en_status,
   output logic       sel_A,
   output logic       sel_B,
   output logic       load_addr,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_err,
   output logic       halted
);

   typedef enum logic [4:0] {
      S_WAIT, S_LA, S_LB, S_EX, S_EXS, S_ST, S_EXZ, S_WB, S_WBI,
      S_AD, S_AL, S_RD, S_WBM, S_LD, S_EXZ2, S_WR, S_HALT
   } state_t;

   // Instruction class remembered so shared states (LA, LB, AD, AL) know where to go next.
   typedef enum logic [2:0] {OP_ADD, OP_CMP, OP_MVN, OP_LDR, OP_STR} op_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             in_mem, timeout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_WAIT;
         op_q    <= OP_ADD;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign in_mem  = (state_q == S_RD) || (state_q == S_WR);
   assign timeout = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      err_d   = err_q;
      case (state_q)
         S_WAIT: if (start) begin
            case (opcode)
               3'b110: if (ALU_op == 2'b10) state_d = S_WBI;
                       else if (ALU_op == 2'b00) begin state_d = S_LB; op_d = OP_MVN; end
               3'b101: case (ALU_op)
                          2'b01:   begin state_d = S_LA; op_d = OP_CMP; end
                          2'b11:   begin state_d = S_LB; op_d = OP_MVN; end
                          default: begin state_d = S_LA; op_d = OP_ADD; end
                       endcase
               3'b011: begin state_d = S_LA; op_d = OP_LDR; end
               3'b100: begin state_d = S_LA; op_d = OP_STR; end
               3'b111: state_d = S_HALT;
               default: state_d = S_WAIT;
            endcase
            if (state_d != S_WAIT && state_d != S_HALT) err_d = 1'b0;
         end
         S_LA:   state_d = (op_q == OP_LDR || op_q == OP_STR) ? S_AD : S_LB;
         S_LB:   state_d = (op_q == OP_MVN) ? S_EXZ : (op_q == OP_CMP) ? S_EXS : S_EX;
         S_EX:   state_d = S_WB;
         S_EXS:  state_d = S_ST;
         S_EXZ:  state_d = S_WB;
         S_AD:   state_d = S_AL;
         S_AL:   state_d = (op_q == OP_STR) ? S_LD : S_RD;
         S_LD:   state_d = S_EXZ2;
         S_EXZ2: state_d = S_WR;
         S_RD, S_WR: begin
            if (mem_ready) state_d = (state_q == S_RD) ? S_WBM : S_WAIT;
            else if (timeout) begin
               state_d = S_WAIT;
               err_d   = 1'b1;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_WAIT;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (in_mem && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      if (!in_mem && (state_d == S_RD || state_d == S_WR)) cnt_d = '0;
   end

   always_comb begin
      waiting = 1'b0; reg_sel = 2'b00; wb_sel = 2'b00; w_en = 1'b0;
      en_A = 1'b0; en_B = 1'b0; en_C = 1'b0; en_status = 1'b0;
      sel_A = 1'b0; sel_B = 1'b0; load_addr = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; halted = 1'b0;
      case (state_q)
         S_WAIT: waiting = 1'b1;
         S_LA:   begin en_A = 1'b1; reg_sel = 2'b10; end
         S_LB:   en_B = 1'b1;
         S_EX:   en_C = 1'b1;
         S_ST:   en_status = 1'b1;
         S_EXZ, S_EXZ2: begin en_C = 1'b1; sel_A = 1'b1; end
         S_WB:   begin w_en = 1'b1; reg_sel = 2'b01; end
         S_WBI:  begin w_en = 1'b1; reg_sel = 2'b10; wb_sel = 2'b10; end
         S_AD:   begin en_C = 1'b1; sel_B = 1'b1; end
         S_AL:   load_addr = 1'b1;
         S_RD:   mem_req = 1'b1;
         S_WBM:  begin w_en = 1'b1; reg_sel = 2'b01; wb_sel = 2'b11; end
         S_LD:   begin en_B = 1'b1; reg_sel = 2'b01; end
         S_WR:   begin mem_req = 1'b1; mem_we = 1'b1; end
         S_HALT: halted = 1'b1;
         default: ;
      endcase
   end

   assign mem_err = err_q;

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with TIMEOUT_CYCLES=4; each cycle's outputs are compared
// as one packed vector against hand-tabulated per-state values.
module tb_mem_controller;

   logic       clk = 1'b0;
   logic       rst_n, start, mem_ready;
   logic [2:0] opcode;
   logic [1:0] ALU_op;
   logic       waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
   logic       load_addr, mem_req, mem_we, mem_err, halted;
   logic [1:0] reg_sel, wb_sel;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   mem_controller #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
      .mem_ready(mem_ready), .waiting(waiting), .reg_sel(reg_sel), .wb_sel(wb_sel),
      .w_en(w_en), .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
      .sel_A(sel_A), .sel_B(sel_B), .load_addr(load_addr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_err(mem_err), .halted(halted)
   );

   // {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B,
   //  load_addr, mem_req, mem_we, mem_err, halted}
   logic [16:0] obs;
   assign obs = {waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
                 sel_A, sel_B, load_addr, mem_req, mem_we, mem_err, halted};

   localparam int K_WAIT = 0, K_LA = 1, K_LB = 2, K_EX = 3, K_NONE = 4, K_ST = 5,
                  K_EXZ = 6, K_WB = 7, K_WBI = 8, K_AD = 9, K_AL = 10, K_RD = 11,
                  K_WBM = 12, K_LD = 13, K_WR = 14, K_HALT = 15;

   function automatic logic [16:0] exp_vec(input int k, input logic me);
      logic [16:0] v;
      case (k)
         K_WAIT: v = 17'b1_00_00_0_0000_00_0_00_0_0;
         K_LA:   v = 17'b0_10_00_0_1000_00_0_00_0_0;
         K_LB:   v = 17'b0_00_00_0_0100_00_0_00_0_0;
         K_EX:   v = 17'b0_00_00_0_0010_00_0_00_0_0;
         K_ST:   v = 17'b0_00_00_0_0001_00_0_00_0_0;
         K_EXZ:  v = 17'b0_00_00_0_0010_10_0_00_0_0;
         K_WB:   v = 17'b0_01_00_1_0000_00_0_00_0_0;
         K_WBI:  v = 17'b0_10_10_1_0000_00_0_00_0_0;
         K_AD:   v = 17'b0_00_00_0_0010_01_0_00_0_0;
         K_AL:   v = 17'b0_00_00_0_0000_00_1_00_0_0;
         K_RD:   v = 17'b0_00_00_0_0000_00_0_10_0_0;
         K_WBM:  v = 17'b0_01_11_1_0000_00_0_00_0_0;
         K_LD:   v = 17'b0_01_00_0_0100_00_0_00_0_0;
         K_WR:   v = 17'b0_00_00_0_0000_00_0_11_0_0;
         K_HALT: v = 17'b0_00_00_0_0000_00_0_00_0_1;
         default: v = '0;
      endcase
      v[1] = me;
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string tag, input int k, input logic me);
      check(tag, {15'd0, obs}, {15'd0, exp_vec(k, me)});
   endtask

   task automatic issue(input logic [2:0] op, input logic [1:0] aop);
      opcode = op; ALU_op = aop; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; opcode = 3'b000; ALU_op = 2'b00;
      step(); step();
      rst_n = 1'b1;
      step();
      expect_st("reset", K_WAIT, 1'b0);

      // ADD
      issue(3'b101, 2'b00); expect_st("add_la", K_LA, 1'b0);
      step(); expect_st("add_lb", K_LB, 1'b0);
      step(); expect_st("add_ex", K_EX, 1'b0);
      step(); expect_st("add_wb", K_WB, 1'b0);
      step(); expect_st("add_done", K_WAIT, 1'b0);

      // Rejected starts
      issue(3'b000, 2'b00); expect_st("bad_opcode", K_WAIT, 1'b0);
      issue(3'b110, 2'b01); expect_st("bad_mov", K_WAIT, 1'b0);

      // MOV immediate
      issue(3'b110, 2'b10); expect_st("movi_wbi", K_WBI, 1'b0);
      step(); expect_st("movi_done", K_WAIT, 1'b0);

      // LDR, ready on 3rd RD cycle; mem_ready outside RD is ignored
      mem_ready = 1'b1;
      issue(3'b011, 2'b00); expect_st("ldr_la", K_LA, 1'b0);
      step(); expect_st("ldr_ad", K_AD, 1'b0);
      step(); expect_st("ldr_al", K_AL, 1'b0);
      mem_ready = 1'b0;
      step(); expect_st("ldr_rd1", K_RD, 1'b0);
      step(); expect_st("ldr_rd2", K_RD, 1'b0);
      step(); expect_st("ldr_rd3", K_RD, 1'b0);
      mem_ready = 1'b1;
      step(); expect_st("ldr_wbm", K_WBM, 1'b0);
      mem_ready = 1'b0;
      step(); expect_st("ldr_done", K_WAIT, 1'b0);

      // STR with timeout
      issue(3'b100, 2'b00); expect_st("str_la", K_LA, 1'b0);
      step(); expect_st("str_ad", K_AD, 1'b0);
      step(); expect_st("str_al", K_AL, 1'b0);
      step(); expect_st("str_ld", K_LD, 1'b0);
      step(); expect_st("str_exz2", K_EXZ, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(); expect_st($sformatf("str_wr%0d", i + 1), K_WR, 1'b0);
      end
      step(); expect_st("str_timeout", K_WAIT, 1'b1);
      step(); expect_st("err_sticky", K_WAIT, 1'b1);
      issue(3'b101, 2'b10); expect_st("and_clears_err", K_LA, 1'b0);
      step(); step(); step(); step(); expect_st("and_done", K_WAIT, 1'b0);

      // LDR with ready on the timeout edge: ready wins
      issue(3'b011, 2'b00); step(); step();
      for (int i = 0; i < 4; i++) begin
         step(); expect_st($sformatf("tie_rd%0d", i + 1), K_RD, 1'b0);
      end
      mem_ready = 1'b1;
      step(); expect_st("tie_wbm", K_WBM, 1'b0);
      mem_ready = 1'b0;
      step(); expect_st("tie_done", K_WAIT, 1'b0);

      // CMP
      issue(3'b101, 2'b01); expect_st("cmp_la", K_LA, 1'b0);
      step(); expect_st("cmp_lb", K_LB, 1'b0);
      step(); expect_st("cmp_exs", K_NONE, 1'b0);
      step(); expect_st("cmp_st", K_ST, 1'b0);
      step(); expect_st("cmp_done", K_WAIT, 1'b0);

      // MVN interrupted by reset in EXZ
      issue(3'b101, 2'b11); expect_st("mvn_lb", K_LB, 1'b0);
      step(); expect_st("mvn_exz", K_EXZ, 1'b0);
      rst_n = 1'b0;
      step(); expect_st("mvn_reset", K_WAIT, 1'b0);
      rst_n = 1'b1;
      step(); expect_st("mvn_no_wb", K_WAIT, 1'b0);

      // HALT
      issue(3'b111, 2'b00); expect_st("halt", K_HALT, 1'b0);
      for (int i = 0; i < 3; i++) begin
         issue(3'b101, 2'b00); expect_st($sformatf("halt_hold%0d", i + 1), K_HALT, 1'b0);
      end
      rst_n = 1'b0;
      step(); expect_st("halt_reset", K_WAIT, 1'b0);
      rst_n = 1'b1;
      step(); expect_st("post_reset", K_WAIT, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
